// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, stage indices and register-number width.
package pipe_pkg;
    typedef enum logic {
        PIPE_RUN  = 1'b0,
        PIPE_PEND = 1'b1
    } pipe_state_e;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;

    localparam int REG_W = 5;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: stall/hazard/flush requests from the datapath,
// register enables, bubble clears, occupancy and counters back to it.
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int N_STAGE     = 5,
    parameter int N_SRC       = 2,
    parameter int LOAD_STAGES = 2,
    parameter int CNT_W       = 32
);
    logic [N_STAGE-1:0]           stall_req;
    logic                         cp0_hazard;
    logic [N_SRC*REG_W-1:0]       id_src;
    logic [N_SRC-1:0]             id_src_vld;
    logic [LOAD_STAGES-1:0]       ld_vld;
    logic [LOAD_STAGES*REG_W-1:0] ld_dest;
    logic                         flush_req;
    logic [N_STAGE-1:0]           en;
    logic [N_STAGE-1:0]           clr;
    logic                         redirect;
    logic [N_STAGE-1:0]           stage_vld;
    logic [CNT_W-1:0]             stall_cnt;
    logic [CNT_W-1:0]             flush_cnt;

    modport master (
        output stall_req, cp0_hazard, id_src, id_src_vld, ld_vld, ld_dest, flush_req,
        input  en, clr, redirect, stage_vld, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall_req, cp0_hazard, id_src, id_src_vld, ld_vld, ld_dest, flush_req,
        output en, clr, redirect, stage_vld, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator array: flags an ID source that matches the nonzero
// destination of any load still too young to forward.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int LOAD_STAGES = 2
) (
    input  logic [N_SRC*REG_W-1:0]       id_src,
    input  logic [N_SRC-1:0]             id_src_vld,
    input  logic [LOAD_STAGES-1:0]       ld_vld,
    input  logic [LOAD_STAGES*REG_W-1:0] ld_dest,
    output logic                         load_hz
);
    always_comb begin
        load_hz = 1'b0;
        for (int j = 0; j < LOAD_STAGES; j++) begin
            for (int s = 0; s < N_SRC; s++) begin
                if (ld_vld[j] && id_src_vld[s]
                    && (ld_dest[j*REG_W +: REG_W] != '0)
                    && (ld_dest[j*REG_W +: REG_W] == id_src[s*REG_W +: REG_W])) begin
                    load_hz = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze-point stall/bubble/flush controller for an N-register in-order
// pipeline, with occupancy tracking and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int N_STAGE     = 5,
    parameter int N_SRC       = 2,
    parameter int LOAD_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int COMMIT = N_STAGE - 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    pipe_state_e        state;
    logic               load_hz;
    logic               fire;
    logic [N_STAGE-1:0] req;
    logic [N_STAGE-1:0] en;
    logic [N_STAGE-1:0] clr;
    logic               redirect;
    logic [N_STAGE-1:0] stage_vld;
    logic [N_STAGE-1:0] vld_in;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    int                 frz;

    load_use_detect #(
        .N_SRC      (N_SRC),
        .LOAD_STAGES(LOAD_STAGES)
    ) u_load_use (
        .id_src    (bus.id_src),
        .id_src_vld(bus.id_src_vld),
        .ld_vld    (bus.ld_vld),
        .ld_dest   (bus.ld_dest),
        .load_hz   (load_hz)
    );

    // A pending flush and a new flush request are the same event; either
    // fires as soon as the commit register is free to advance.
    assign fire = ((state == PIPE_PEND) || bus.flush_req) && !bus.stall_req[COMMIT];

    always_comb begin
        req = bus.stall_req;
        req[STG_ID] = bus.stall_req[STG_ID] | load_hz | bus.cp0_hazard;

        frz = -1;
        for (int k = 0; k < N_STAGE; k++) begin
            if (req[k]) frz = k;
        end

        en       = '1;
        clr      = '0;
        redirect = 1'b0;
        if (!rst_n) begin
            clr = '1;
        end else if (fire) begin
            redirect = 1'b1;
            for (int k = 1; k < COMMIT; k++) clr[k] = 1'b1;
        end else begin
            for (int k = 0; k < N_STAGE; k++) begin
                en[k]  = (k > frz);
                clr[k] = (frz >= 0) && (k == frz + 1);
            end
        end
    end

    // Stage 0 always fetches a real instruction when it loads.
    assign vld_in = {stage_vld[N_STAGE-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PIPE_RUN;
            stage_vld <= {{(N_STAGE-1){1'b0}}, 1'b1};
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                PIPE_RUN:  if (bus.flush_req && bus.stall_req[COMMIT]) state <= PIPE_PEND;
                PIPE_PEND: if (!bus.stall_req[COMMIT]) state <= PIPE_RUN;
                default:   state <= PIPE_RUN;
            endcase
            for (int k = 0; k < N_STAGE; k++) begin
                if (en[k]) stage_vld[k] <= clr[k] ? 1'b0 : vld_in[k];
            end
            if (en != '1) stall_cnt <= sat_inc(stall_cnt);
            if (redirect) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign bus.en        = en;
    assign bus.clr       = clr;
    assign bus.redirect  = redirect;
    assign bus.stage_vld = stage_vld;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
endmodule
